mem_port_arbiter: RTL

Arbitrates the processor's single-ported memory between the fetch stage (read-only instruction requests) and the memory stage (data loads/stores). Requests are serviced one at a time with a request/acknowledge handshake on both sides. The per-requester stall outputs feed the pipeline's stall logic. A watchdog and optional performance counters support simulation-trace debugging and CPI measurement.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported memory: data wins ties, grants alternate on completion.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_stall_o,

    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic                dm_ack_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_stall_o,

    output logic                bus_err_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic [31:0]         perf_if_cnt_o,
    output logic [31:0]         perf_dm_cnt_o,
    output logic [31:0]         perf_conf_cnt_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t              state_q;
    logic [WD_W-1:0]     wd_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;

    logic busy;
    logic expire;
    logic done;
    logic grant_if_d;
    logic grant_dm_d;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

    // wd_q counts completed BUSY cycles, so it equals TIMEOUT-1 in the TIMEOUT-th one
    generate
        if (TIMEOUT == 0) begin : g_no_wd
            assign expire = 1'b0;
        end else begin : g_wd
            assign expire = busy && (wd_q == WD_W'(TIMEOUT - 1));
        end
    endgenerate

    assign done = busy && (mem_ack_i || expire);

    always_comb begin
        grant_if_d = 1'b0;
        grant_dm_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_dm_d = dm_req_i;
                grant_if_d = !dm_req_i && if_req_i;
            end
            BUSY_IF: grant_dm_d = done && dm_req_i;
            BUSY_DM: grant_if_d = done && if_req_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (grant_dm_d) begin
            state_q     <= BUSY_DM;
            wd_q        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            mem_be_q    <= dm_be_i;
        end else if (grant_if_d) begin
            state_q     <= BUSY_IF;
            wd_q        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
        end else if (done) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
        end else if (busy) begin
            wd_q        <= wd_q + 1'b1;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

    assign if_ack_o   = done && (state_q == BUSY_IF);
    assign dm_ack_o   = done && (state_q == BUSY_DM);
    assign if_rdata_o = (if_ack_o && mem_ack_i) ? mem_rdata_i : '0;
    assign dm_rdata_o = (dm_ack_o && mem_ack_i) ? mem_rdata_i : '0;
    assign bus_err_o  = done && !mem_ack_i;
    assign if_stall_o = if_req_i && !if_ack_o;
    assign dm_stall_o = dm_req_i && !dm_ack_o;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_dm_q;
    logic [31:0] perf_conf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_if_q   <= '0;
            perf_dm_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            if (if_ack_o) perf_if_q <= perf_if_q + 32'd1;
            if (dm_ack_o) perf_dm_q <= perf_dm_q + 32'd1;
            if (if_req_i && dm_req_i && !(if_ack_o && dm_ack_o))
                perf_conf_q <= perf_conf_q + 32'd1;
        end
    end

    assign perf_if_cnt_o   = perf_if_q;
    assign perf_dm_cnt_o   = perf_dm_q;
    assign perf_conf_cnt_o = perf_conf_q;
`else
    assign perf_if_cnt_o   = '0;
    assign perf_dm_cnt_o   = '0;
    assign perf_conf_cnt_o = '0;
`endif

endmodule
